// File: rtl/mul_div_seq_pkg.sv
// Shared state encodings and opcode constants for the sequential multiply/divide unit.
package mul_div_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic OP_MUL = 1'b0;
   localparam logic OP_DIV = 1'b1;

endpackage

// File: rtl/mul_div_step.sv
// One iteration of either shift-add multiply (MSB-first) or restoring division,
// operating on unsigned magnitudes.
module mul_div_step
   import mul_div_seq_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               op,
   input  logic [2*WIDTH-1:0] accIn,
   input  logic [WIDTH:0]     remIn,
   input  logic               opBit,
   input  logic [WIDTH-1:0]   operand,
   output logic [2*WIDTH-1:0] accOut,
   output logic [WIDTH:0]     remOut,
   output logic               qBit
);

   logic [WIDTH+1:0] shifted;
   logic [WIDTH+1:0] diff;

   // Multiply doubles the accumulator and adds the multiplicand when the current
   // multiplier bit is set. Divide shifts the next dividend bit into the partial
   // remainder and keeps the trial subtraction only when it does not go negative.
   always_comb begin
      accOut  = accIn;
      remOut  = remIn;
      qBit    = 1'b0;
      shifted = {remIn, opBit};
      diff    = shifted - {2'b00, operand};
      if (op == OP_MUL) begin
         accOut = {accIn[2*WIDTH-2:0], 1'b0} +
                  (opBit ? {{WIDTH{1'b0}}, operand} : {(2*WIDTH){1'b0}});
      end else begin
         qBit   = ~diff[WIDTH+1];
         remOut = qBit ? diff[WIDTH:0] : shifted[WIDTH:0];
      end
   end

endmodule

// File: rtl/mul_div_seq.sv
// Iterative signed multiply/divide, one bit per clock, fixed latency of WIDTH+2
// edges; writes the Z register through Result/ZIn.
module mul_div_seq
   import mul_div_seq_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               clr,
   input  logic               start,
   input  logic               op,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   output logic [2*WIDTH-1:0] Result,
   output logic               ZIn,
   output logic               done,
   output logic               busy,
   output logic               div_zero
);

   localparam int CW = $clog2(WIDTH);

   state_t               state;
   logic [CW-1:0]        count;
   logic                 opReg;
   logic                 signA;
   logic                 signB;
   logic [WIDTH-1:0]     magA;
   logic [WIDTH-1:0]     magB;
   logic [WIDTH-1:0]     shiftReg;
   logic [WIDTH-1:0]     quot;
   logic [2*WIDTH-1:0]   acc;
   logic [WIDTH:0]       rem;

   logic [WIDTH-1:0]     absA;
   logic [WIDTH-1:0]     absB;
   logic [WIDTH-1:0]     operand;
   logic [2*WIDTH-1:0]   accNext;
   logic [WIDTH:0]       remNext;
   logic                 qBit;

   logic                 negRes;
   logic [2*WIDTH-1:0]   prodFix;
   logic [WIDTH-1:0]     quotFix;
   logic [WIDTH-1:0]     remFix;
   logic [WIDTH-1:0]     origA;

   assign absA    = A[WIDTH-1] ? (~A + 1'b1) : A;
   assign absB    = B[WIDTH-1] ? (~B + 1'b1) : B;
   assign operand = (opReg == OP_MUL) ? magA : magB;

   mul_div_step #(.WIDTH(WIDTH)) step (
      .op      (opReg),
      .accIn   (acc),
      .remIn   (rem),
      .opBit   (shiftReg[WIDTH-1]),
      .operand (operand),
      .accOut  (accNext),
      .remOut  (remNext),
      .qBit    (qBit)
   );

   // Sign fix-up: product and quotient follow sign(A) XOR sign(B), the remainder
   // follows the dividend, and the original A is rebuilt from its magnitude for
   // the divide-by-zero result.
   always_comb begin
      negRes  = signA ^ signB;
      prodFix = negRes ? (~acc + 1'b1) : acc;
      quotFix = negRes ? (~quot + 1'b1) : quot;
      remFix  = signA ? (~rem[WIDTH-1:0] + 1'b1) : rem[WIDTH-1:0];
      origA   = signA ? (~magA + 1'b1) : magA;
   end

   // Control FSM with registered outputs. The shift register feeds operand bits
   // MSB first: the multiplier for MUL, the dividend for DIV.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state    <= IDLE;
         count    <= '0;
         opReg    <= OP_MUL;
         signA    <= 1'b0;
         signB    <= 1'b0;
         magA     <= '0;
         magB     <= '0;
         shiftReg <= '0;
         quot     <= '0;
         acc      <= '0;
         rem      <= '0;
         Result   <= '0;
         ZIn      <= 1'b0;
         done     <= 1'b0;
         busy     <= 1'b0;
         div_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= RUN;
                  busy     <= 1'b1;
                  count    <= '0;
                  opReg    <= op;
                  signA    <= A[WIDTH-1];
                  signB    <= B[WIDTH-1];
                  magA     <= absA;
                  magB     <= absB;
                  shiftReg <= (op == OP_MUL) ? absB : absA;
                  quot     <= '0;
                  acc      <= '0;
                  rem      <= '0;
                  div_zero <= (op == OP_DIV) && (B == '0);
               end
            end
            RUN: begin
               acc      <= accNext;
               rem      <= remNext;
               quot     <= {quot[WIDTH-2:0], qBit};
               shiftReg <= {shiftReg[WIDTH-2:0], 1'b0};
               count    <= count + 1'b1;
               if (count == CW'(WIDTH-1)) state <= FIX;
            end
            FIX: begin
               if (opReg == OP_MUL)   Result <= prodFix;
               else if (div_zero)     Result <= {origA, {WIDTH{1'b1}}};
               else                   Result <= {remFix, quotFix};
               done  <= 1'b1;
               ZIn   <= 1'b1;
               state <= DONE;
            end
            DONE: begin
               done  <= 1'b0;
               ZIn   <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_div_seq.sv
// Self-checking bench for mul_div_seq: directed vector table, randomized ops against
// an arithmetic reference model, and hand-written multi-cycle sequences.
module tb_mul_div_seq;
   import mul_div_seq_pkg::*;

   localparam int W = 32;

   logic           clk;
   logic           clr;
   logic           start;
   logic           op;
   logic [W-1:0]   A;
   logic [W-1:0]   B;
   logic [2*W-1:0] Result;
   logic           ZIn;
   logic           done;
   logic           busy;
   logic           div_zero;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic           op;
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic [2*W-1:0] expRes;
      logic           expDz;
   } vec_t;

   vec_t vecs[10];

   mul_div_seq #(.WIDTH(W)) dut (
      .clk      (clk),
      .clr      (clr),
      .start    (start),
      .op       (op),
      .A        (A),
      .B        (B),
      .Result   (Result),
      .ZIn      (ZIn),
      .done     (done),
      .busy     (busy),
      .div_zero (div_zero)
   );

   // Free-running clock, 10 time units per period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Safety net in case any bounded loop is mis-sized
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [2*W-1:0] refModel(input logic o, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
      longint sa, sb, q, r, p;
      logic [W-1:0] q32, r32;
      logic [2*W-1:0] res;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (o == OP_MUL) begin
         p   = sa * sb;
         res = p;
      end else if (sb == 0) begin
         res = {a, {W{1'b1}}};
      end else begin
         q   = sa / sb;
         r   = sa % sb;
         q32 = q[W-1:0];
         r32 = r[W-1:0];
         res = {r32, q32};
      end
      return res;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Start one operation and watch the following cycles for the done pulse
   task automatic applyStimulus(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [2*W-1:0] expRes, input logic expDz, input string name);
      int doneAt;
      int doneCount;
      logic zinAtDone, busyEarly, busyAfter;
      logic [2*W-1:0] resAtDone;
      logic dzAtDone;
      doneAt = -1; doneCount = 0; zinAtDone = 1'b0; busyEarly = 1'b0; busyAfter = 1'b1;
      resAtDone = '0; dzAtDone = 1'b0;
      @(negedge clk);
      start = 1'b1; op = o; A = a; B = b;
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 0; k <= W + 4; k++) begin
         @(negedge clk);
         if (k == 0) busyEarly = busy;
         if (done) begin
            doneCount++;
            if (doneAt < 0) begin
               doneAt = k; zinAtDone = ZIn; resAtDone = Result; dzAtDone = div_zero;
            end
         end
         if (k == W + 2) busyAfter = busy;
      end
      checkOutput({name, " latency"}, 64'(doneAt), 64'(W + 1));
      checkOutput({name, " doneCount"}, 64'(doneCount), 64'd1);
      checkOutput({name, " Result"}, resAtDone, expRes);
      checkOutput({name, " ZIn"}, 64'(zinAtDone), 64'd1);
      checkOutput({name, " div_zero"}, 64'(dzAtDone), 64'(expDz));
      checkOutput({name, " busyEarly"}, 64'(busyEarly), 64'd1);
      checkOutput({name, " busyAfter"}, 64'(busyAfter), 64'd0);
   endtask

   initial begin
      int firstDone, secondDone, nDone;
      logic [W-1:0] ra, rb;
      logic ro;

      vecs[0] = '{OP_MUL, 32'd7,          32'hFFFFFFFD, 64'hFFFFFFFF_FFFFFFEB, 1'b0};
      vecs[1] = '{OP_DIV, 32'hFFFFFFF9,   32'd2,        64'hFFFFFFFF_FFFFFFFD, 1'b0};
      vecs[2] = '{OP_DIV, 32'd5,          32'd0,        64'h00000005_FFFFFFFF, 1'b1};
      vecs[3] = '{OP_MUL, 32'd2,          32'd3,        64'h00000000_00000006, 1'b0};
      vecs[4] = '{OP_MUL, 32'h80000000,   32'h80000000, 64'h40000000_00000000, 1'b0};
      vecs[5] = '{OP_DIV, 32'h80000000,   32'hFFFFFFFF, 64'h00000000_80000000, 1'b0};
      vecs[6] = '{OP_DIV, 32'd100,        32'd7,        64'h00000002_0000000E, 1'b0};
      vecs[7] = '{OP_DIV, 32'hFFFFFF9C,   32'hFFFFFFF9, 64'hFFFFFFFE_0000000E, 1'b0};
      vecs[8] = '{OP_MUL, 32'hFFFFFFFF,   32'hFFFFFFFF, 64'h00000000_00000001, 1'b0};
      vecs[9] = '{OP_MUL, 32'h7FFFFFFF,   32'h7FFFFFFF, 64'h3FFFFFFF_00000001, 1'b0};

      clr = 1'b1; start = 1'b0; op = OP_MUL; A = '0; B = '0;
      repeat (3) @(negedge clk);
      checkOutput("reset Result", Result, 64'd0);
      checkOutput("reset flags", {60'd0, done, ZIn, busy, div_zero}, 64'd0);
      clr = 1'b0;

      for (int i = 0; i < 10; i++)
         applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].expRes, vecs[i].expDz,
                       $sformatf("vec%0d", i));

      for (int i = 0; i < 40; i++) begin
         ro = 1'($urandom_range(0, 1));
         ra = $urandom;
         rb = $urandom;
         if ($urandom_range(0, 7) == 0) rb = '0;
         else if ($urandom_range(0, 3) == 0) rb = W'($urandom_range(0, 16)) - W'(8);
         applyStimulus(ro, ra, rb, refModel(ro, ra, rb), (ro == OP_DIV) && (rb == '0),
                       $sformatf("rand%0d", i));
      end

      // start held high: one done every W+3 cycles
      firstDone = -1; secondDone = -1; nDone = 0;
      @(negedge clk);
      start = 1'b1; op = OP_MUL; A = 32'd3; B = 32'd5;
      for (int k = 0; k < 80; k++) begin
         @(negedge clk);
         if (done) begin
            nDone++;
            if (firstDone < 0) firstDone = k;
            else if (secondDone < 0) secondDone = k;
         end
      end
      start = 1'b0;
      checkOutput("held doneCount", 64'(nDone), 64'd2);
      checkOutput("held first", 64'(firstDone), 64'(W + 1));
      checkOutput("held period", 64'(secondDone - firstDone), 64'(W + 3));
      repeat (W + 5) @(negedge clk);
      checkOutput("held Result", Result, 64'd15);
      checkOutput("held idle", 64'(busy), 64'd0);

      // start pulsed during RUN is ignored and Result holds the previous value
      applyStimulus(OP_MUL, 32'd2, 32'd3, 64'd6, 1'b0, "pre-ignore");
      @(negedge clk);
      start = 1'b1; op = OP_MUL; A = 32'd7; B = 32'hFFFFFFFD;
      @(posedge clk);
      #1 start = 1'b0;
      nDone = 0; firstDone = -1;
      for (int k = 0; k <= W + 4; k++) begin
         @(negedge clk);
         if (k == 5) begin start = 1'b1; op = OP_DIV; A = 32'd1; B = 32'd0; end
         if (k == 7) start = 1'b0;
         if (k == 10) checkOutput("ignore heldResult", Result, 64'd6);
         if (done) begin nDone++; if (firstDone < 0) firstDone = k; end
      end
      checkOutput("ignore doneCount", 64'(nDone), 64'd1);
      checkOutput("ignore latency", 64'(firstDone), 64'(W + 1));
      checkOutput("ignore Result", Result, 64'hFFFFFFFF_FFFFFFEB);
      checkOutput("ignore div_zero", 64'(div_zero), 64'd0);

      // asynchronous clr mid-RUN aborts the operation
      applyStimulus(OP_DIV, 32'd9, 32'd0, 64'h00000009_FFFFFFFF, 1'b1, "pre-clr");
      @(negedge clk);
      start = 1'b1; op = OP_DIV; A = 32'd9; B = 32'd0;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (10) @(posedge clk);
      #2 clr = 1'b1;
      #1;
      checkOutput("clr Result", Result, 64'd0);
      checkOutput("clr flags", {60'd0, done, ZIn, busy, div_zero}, 64'd0);
      @(negedge clk);
      clr = 1'b0;
      nDone = 0;
      for (int k = 0; k < W + 10; k++) begin
         @(negedge clk);
         if (done) nDone++;
      end
      checkOutput("clr noDone", 64'(nDone), 64'd0);
      checkOutput("clr busy", 64'(busy), 64'd0);
      applyStimulus(OP_MUL, 32'hFFFFFFFB, 32'd6, 64'hFFFFFFFF_FFFFFFE2, 1'b0, "post-clr");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
